// File: rtl/iter_alu_if.sv
// Request/response bundle for the iterative ALU.
// The master drives the operation request, and the slave returns the status and the result.
interface iter_alu_if #(
  parameter int WIDTH = 32
) ();
  logic             start_i;
  logic [3:0]       alu_control_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;

  modport master (
    output start_i, alu_control_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o
  );

  modport slave (
    input  start_i, alu_control_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle ALU. Non-shift ops finish in one cycle.
// Shifts move the working register by one bit per cycle.
module iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  iter_alu_if.slave bus
);

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] SHIFT     = 2'b01;
  localparam logic [1:0] DONE_PEND = 2'b10;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BGE = 4'b1000;
  localparam logic [3:0] OP_XOR = 4'b1001;

  logic [1:0]       state_q,  state_d;
  logic [3:0]       op_q,     op_d;
  logic [4:0]       cnt_q,    cnt_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q,   zero_d;
  logic [WIDTH-1:0] shifted_s;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      OP_ADD:         r = a + b;
      OP_SUB:         r = a - b;
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      OP_SLT, OP_BGE: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:        r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
      default: r = w;
    endcase
    return r;
  endfunction

  assign shifted_s = shift_one(op_q, work_q);

  // Next-state and datapath selection
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          op_d = bus.alu_control_i;
          if (is_shift(bus.alu_control_i)) begin
            work_d = bus.a_i;
            cnt_d  = bus.b_i[4:0];
            if (bus.b_i[4:0] == 5'd0) begin
              result_d = bus.a_i;
              state_d  = DONE_PEND;
            end else begin
              state_d  = SHIFT;
            end
          end else begin
            result_d = alu_compute(bus.alu_control_i, bus.a_i, bus.b_i);
            state_d  = DONE_PEND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = shifted_s;
        cnt_d  = cnt_q - 5'd1;
        // Counter of 1 here means this shift is the last one.
        if (cnt_q == 5'd1) begin
          result_d = shifted_s;
          state_d  = DONE_PEND;
        end else begin
          state_d  = SHIFT;
        end
      end
      DONE_PEND: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    zero_d = (result_d == {WIDTH{1'b0}});
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= 4'd0;
      cnt_q    <= 5'd0;
      work_q   <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy_o   = (state_q == SHIFT) || (state_q == DONE_PEND);
  assign bus.done_o   = (state_q == DONE_PEND);
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomised and directed bench for iter_alu.
// Results come from a plain-arithmetic model of the opcode table.
module tb_iter_alu;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  iter_alu_if #(.WIDTH(32)) bus ();

  iter_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      4'd0:       return a + b;
      4'd1:       return a - b;
      4'd2:       return a & b;
      4'd3:       return a | b;
      4'd4:       return a << sh;
      4'd5, 4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:       return a >> sh;
      4'd7:       return $unsigned($signed(a) >>> sh);
      4'd9:       return a ^ b;
      default:    return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'd4 || op == 4'd6 || op == 4'd7) && (b % 32) != 0)
      return int'(b % 32) + 1;
    return 1;
  endfunction

  // Issue one request when idle; lat = cycles from acceptance edge to visible done.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (bus.busy_o && g < 200) begin
      @(negedge clk);
      g++;
    end
    bus.start_i       = 1'b1;
    bus.alu_control_i = op;
    bus.a_i           = a;
    bus.b_i           = b;
    @(posedge clk);
    #1;
    bus.start_i       = 1'b0;
    bus.alu_control_i = 4'($urandom);
    bus.a_i           = $urandom;
    bus.b_i           = $urandom;
    lat = 1;
    while (!bus.done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.alu_control_i = 4'd0;
    bus.a_i = 32'd0;
    bus.b_i = 32'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b expected 0/0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.result_o !== 32'd0 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_result result=%h zero=%b expected 0/1", bus.result_o, bus.zero_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops  [8] = '{4'd0, 4'd7, 4'd6, 4'd4, 4'd8, 4'd8, 4'd1, 4'd12};
    logic [31:0] as   [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h12345678,
                              32'hFFFFFFFE, 32'h5, 32'h0, 32'hDEADBEEF};
    logic [31:0] bs   [8] = '{32'h1, 32'h1F, 32'h1F, 32'h20, 32'h1, 32'h5, 32'h1, 32'h1234};
    logic [31:0] exp_r[8] = '{32'h0, 32'hFFFFFFFF, 32'h1, 32'h12345678, 32'h1, 32'h0,
                              32'hFFFFFFFF, 32'h0};
    logic        exp_z[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int          exp_l[8] = '{1, 32, 32, 1, 1, 1, 1, 1};
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      checks++;
      if (lat !== exp_l[i] || bus.result_o !== exp_r[i] || bus.zero_o !== exp_z[i]) begin
        errors++;
        $display("FAIL directed_%0d lat=%0d result=%h zero=%b expected lat=%0d result=%h zero=%b",
                 i, lat, bus.result_o, bus.zero_o, exp_l[i], exp_r[i], exp_z[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, er;
    int lat, el;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom);
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      er = model_result(op, a, b);
      el = model_latency(op, b);
      run_op(op, a, b, lat);
      checks++;
      if (lat !== el || bus.result_o !== er || bus.zero_o !== (er == 32'd0)) begin
        errors++;
        $display("FAIL random_%0d op=%h a=%h b=%h lat=%0d result=%h zero=%b expected lat=%0d result=%h",
                 i, op, a, b, lat, bus.result_o, bus.zero_o, el, er);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== er) begin
        errors++;
        $display("FAIL random_after_%0d done=%b busy=%b result=%h expected 0/0/%h",
                 i, bus.done_o, bus.busy_o, bus.result_o, er);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [31:0] res;
    dones = 0;
    res = 32'd0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.alu_control_i = 4'd4; bus.a_i = 32'h000000F3; bus.b_i = 32'd4;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start_i = (i < 2);
      bus.alu_control_i = 4'd0; bus.a_i = 32'd1; bus.b_i = 32'd2;
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        dones++;
        res = bus.result_o;
      end
    end
    checks++;
    if (dones !== 1 || res !== 32'h00000F30) begin
      errors++;
      $display("FAIL ignore_start dones=%0d result=%h expected 1/00000f30", dones, res);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start_i = 1'b1; bus.alu_control_i = 4'd9; bus.a_i = 32'hF0F0F0F0; bus.b_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.result_o !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL b2b_first done=%b result=%h expected 1/0f0f0f0f", bus.done_o, bus.result_o);
    end
    @(negedge clk);
    bus.alu_control_i = 4'd0; bus.a_i = 32'd10; bus.b_i = 32'd20;
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 32'h0F0F0F0F) begin
      errors++;
      $display("FAIL b2b_gap done=%b busy=%b result=%h expected 0/0/0f0f0f0f",
               bus.done_o, bus.busy_o, bus.result_o);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.done_o !== 1'b1 || bus.result_o !== 32'd30) begin
      errors++;
      $display("FAIL b2b_second done=%b result=%h expected 1/0000001e", bus.done_o, bus.result_o);
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset_mid_shift();
    int dones, lat;
    dones = 0;
    @(negedge clk);
    @(negedge clk);
    bus.start_i = 1'b1; bus.alu_control_i = 4'd4; bus.a_i = 32'h1; bus.b_i = 32'd10;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== 32'd0 || bus.zero_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset busy=%b done=%b result=%h zero=%b expected 0/0/0/1",
               bus.busy_o, bus.done_o, bus.result_o, bus.zero_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dones++;
    end
    checks++;
    if (dones !== 0 || bus.result_o !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_nodone dones=%0d result=%h expected 0/0", dones, bus.result_o);
    end
    run_op(4'd9, 32'hF0F0F0F0, 32'hFFFFFFFF, lat);
    checks++;
    if (lat !== 1 || bus.result_o !== 32'h0F0F0F0F || bus.zero_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_xor lat=%0d result=%h zero=%b expected 1/0f0f0f0f/0",
               lat, bus.result_o, bus.zero_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; SHALL support WIDTH = 32 only for shift-amount extraction (shamt = b[4:0]).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ALUControl  input  4  operation code from the ALU decoder, sampled with start.
REQ-006 a  input  WIDTH  operand A (rs1), sampled with start.
REQ-007 b  input  WIDTH  operand B (rs2/imm), sampled with start.
REQ-008 busy  output  1  high while an operation is in progress (SHIFT or DONE_PEND states).
REQ-009 done  output  1  single-cycle pulse, result valid.
REQ-010 result  output  WIDTH  operation result; held stable from done until next accepted start.
REQ-011 zero  output  1  (result == 0), registered with result.

Function
REQ-012 Op codes SHALL be: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed), 0110 srl, 0111 sra, 1000 bge-compare, 1001 xor; 1010-1111 SHALL produce result 0.
REQ-013 add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-014 slt and 1000 SHALL return {0..0,1} when signed a < b, else 0; for 1000, zero=1 means a >= b (branch taken).
REQ-015 FSM states IDLE, SHIFT, DONE_PEND; reset state IDLE.
REQ-016 IDLE: start=1 with non-shift op -> compute, register result, go DONE_PEND.
REQ-017 IDLE: start=1 with shift op (0100/0110/0111) -> load working register with a, counter with b[4:0]; counter=0 -> DONE_PEND, else SHIFT.
REQ-018 SHIFT: each cycle shift working register one bit (sll: insert 0 at LSB; srl: insert 0 at MSB; sra: replicate MSB), decrement counter; on counter reaching 0 after the shift -> DONE_PEND.
REQ-019 DONE_PEND: done=1 for exactly one cycle, result/zero updated in the same cycle, next state IDLE.
REQ-020 Latency: start accepted at edge N -> done high in cycle after edge N+1 for non-shifts and shamt=0; done after edge N+1+shamt for shifts (shamt 1..31).
REQ-021 start while busy=1 SHALL be ignored; operands/op captured at acceptance SHALL not be affected by later input changes.
REQ-022 start in the cycle done=1 SHALL be ignored (block is in DONE_PEND); accepted from the next IDLE cycle.
REQ-023 b[WIDTH-1:5] SHALL be ignored for shifts; shamt 31 SHALL take 31 SHIFT cycles.
REQ-024 busy SHALL be combinational from state: 1 in SHIFT and DONE_PEND, 0 in IDLE; done SHALL be 1 only in DONE_PEND.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, zero=1, counter=0, independent of clk.
REQ-026 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; first start after rst_n rises SHALL be accepted normally.
REQ-027 rst_n deassertion SHALL be synchronised by the integrator; block assumes release away from clk edge.

Verification
REQ-028 add: a=0xFFFFFFFF, b=0x1, op 0000 -> done 1 cycle after start, result=0x00000000, zero=1.
REQ-029 sra: a=0x80000000, b=0x0000001F, op 0111 -> busy 32 cycles, done after 32 cycles, result=0xFFFFFFFF; srl same operands -> result=0x00000001.
REQ-030 sll shamt 0: a=0x12345678, b=0x20 (b[4:0]=0), op 0100 -> done after 1 cycle, result=0x12345678.
REQ-031 bge-compare: a=0xFFFFFFFE (-2), b=0x1, op 1000 -> result=1, zero=0; a=0x5, b=0x5 -> result=0, zero=1.
REQ-032 start pulsed during sll by 4 with different operands -> ignored; single done, result = original a<<4; start held high through done -> second op accepted the cycle after done.
REQ-033 rst_n low 2 cycles into sll by 10 -> busy=0, done never pulses, result=0, zero=1; subsequent xor a=0xF0F0F0F0, b=0xFFFFFFFF -> result=0x0F0F0F0F.
